ntsc_timing_ctrl: RTL

//  Scheduler for the NTSC composite chroma/luma datapath. It runs the horizontal and vertical counters and generates

---
 rtl/ntsc_timing_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ntsc_timing_ctrl.sv
// NTSC horizontal/vertical timing generator feeding the chroma/luma datapath.
// Outputs are pipelined so active_dly/cb_dly line up with luma valid and luma_sync_d2 trails them by two clocks.
module ntsc_timing_ctrl #(
   parameter int unsigned H_TOTAL   = 2034,
   parameter int unsigned H_SYNC    = 150,
   parameter int unsigned H_BROAD   = 867,
   parameter int unsigned BURST_ST  = 170,
   parameter int unsigned BURST_LEN = 80,
   parameter int unsigned ACT_ST    = 300,
   parameter int unsigned ACT_LEN   = 1664,
   parameter int unsigned V_TOTAL   = 262,
   parameter int unsigned V_ACT_ST  = 20,
   parameter int unsigned V_ACT_LEN = 240,
   parameter int unsigned BLANK_LVL = 4
) (
   input  logic        clk_2x,
   input  logic        reset,
   input  logic        enable,
   input  logic [3:0]  luma,
   output logic        pix_req,
   output logic [10:0] pix_x,
   output logic [7:0]  pix_y,
   output logic        active_dly,
   output logic        cb_dly,
   output logic [3:0]  luma_sync_d2,
   output logic        frame_start,
   output logic [10:0] hcount,
   output logic [8:0]  vcount
);

   localparam int unsigned HW     = 11;
   localparam int unsigned VW     = 9;
   localparam int unsigned YW     = 8;
   localparam int unsigned LW     = 4;
   localparam int unsigned H_EQ   = H_SYNC / 2;
   localparam int unsigned H_HALF = H_TOTAL / 2;

   if (BURST_ST + BURST_LEN > ACT_ST) begin : g_window_overlap
      $error("burst window overlaps active window");
   end

   logic          eq_line;
   logic          vs_line;
   logic          act_line;
   logic          sync_lo;
   logic          burst_win;
   logic          act_win;
   logic [HW-1:0] hcount_nxt;
   logic [VW-1:0] vcount_nxt;
   logic          burst_s0;
   logic          sync_s0;
   logic          sync_s1;
   logic [LW-1:0] level_nxt;
   logic [LW-1:0] level_s2;

   // Line type and window decode for the current counter position
   always_comb begin
      eq_line  = (vcount <= VW'(2)) || ((vcount >= VW'(6)) && (vcount <= VW'(8)));
      vs_line  = (vcount >= VW'(3)) && (vcount <= VW'(5));
      act_line = (vcount >= VW'(V_ACT_ST)) && (vcount < VW'(V_ACT_ST + V_ACT_LEN));
      if (eq_line) begin
         sync_lo = (hcount < HW'(H_EQ)) ||
                   ((hcount >= HW'(H_HALF)) && (hcount < HW'(H_HALF + H_EQ)));
      end else if (vs_line) begin
         sync_lo = (hcount < HW'(H_BROAD)) ||
                   ((hcount >= HW'(H_HALF)) && (hcount < HW'(H_HALF + H_BROAD)));
      end else begin
         sync_lo = (hcount < HW'(H_SYNC));
      end
      burst_win = !eq_line && !vs_line &&
                  (hcount >= HW'(BURST_ST)) && (hcount < HW'(BURST_ST + BURST_LEN));
      act_win   = act_line &&
                  (hcount >= HW'(ACT_ST)) && (hcount < HW'(ACT_ST + ACT_LEN));
   end

   always_comb begin
      hcount_nxt = hcount;
      vcount_nxt = vcount;
      if (enable) begin
         if (hcount == HW'(H_TOTAL - 1)) begin
            hcount_nxt = '0;
            vcount_nxt = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
         end else begin
            hcount_nxt = hcount + HW'(1);
         end
      end
      // Sync tip wins over active video; everything else is blank level
      if (sync_s1) begin
         level_nxt = '0;
      end else if (active_dly) begin
         level_nxt = luma;
      end else begin
         level_nxt = LW'(BLANK_LVL);
      end
   end

   always_ff @(posedge clk_2x) begin
      if (reset) begin
         hcount      <= '0;
         vcount      <= '0;
         pix_req     <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         burst_s0    <= 1'b0;
         sync_s0     <= 1'b0;
      end else begin
         hcount      <= hcount_nxt;
         vcount      <= vcount_nxt;
         pix_req     <= enable && act_win;
         pix_x       <= (enable && act_win) ? hcount - HW'(ACT_ST) : '0;
         pix_y       <= (enable && act_win) ? YW'(vcount - VW'(V_ACT_ST)) : '0;
         frame_start <= enable && (hcount == '0) && (vcount == '0);
         burst_s0    <= enable && burst_win;
         sync_s0     <= enable && sync_lo;
      end
   end

   // S1..S3: flags travel with the data so every output stays aligned
   always_ff @(posedge clk_2x) begin
      if (reset) begin
         active_dly   <= 1'b0;
         cb_dly       <= 1'b0;
         sync_s1      <= 1'b0;
         level_s2     <= '0;
         luma_sync_d2 <= '0;
      end else begin
         active_dly   <= pix_req;
         cb_dly       <= burst_s0;
         sync_s1      <= sync_s0;
         level_s2     <= level_nxt;
         luma_sync_d2 <= level_s2;
      end
   end

endmodule
